// File: rtl/tx_pkg.sv
// Shared constants, state encoding and header/trailer word layouts for the tx stream packer.
package tx_pkg;

    localparam logic [7:0]  HDR_SYNC  = 8'hA5;
    localparam logic [7:0]  TRL_SYNC  = 8'h5A;
    localparam int unsigned HDR_CH_W  = 4;
    localparam int unsigned SEQ_W     = 16;
    localparam int unsigned PKT_CNT_W = 16;
    localparam int unsigned DROP_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_TRL
    } state_e;

    typedef struct packed {
        logic [7:0]          sync;
        logic [HDR_CH_W-1:0] ch;
        logic [3:0]          rsvd;
        logic [SEQ_W-1:0]    seq;
    } hdr_word_t;

    typedef struct packed {
        logic [7:0]           sync;
        logic [7:0]           rsvd;
        logic [PKT_CNT_W-1:0] pkt_cnt;
    } trl_word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last granted index.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_c_o
);

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] last_d;

    // Scan from farthest to nearest offset so the nearest requester wins.
    always_comb begin
        grant_c_o = '0;
        last_d    = last_q;
        for (int off = int'(N); off >= 1; off--) begin
            if (req_i[IDX_W'((32'(last_q) + 32'(off)) % N)]) begin
                grant_c_o = '0;
                grant_c_o[IDX_W'((32'(last_q) + 32'(off)) % N)] = 1'b1;
                last_d    = IDX_W'((32'(last_q) + 32'(off)) % N);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IDX_W'(N - 1);
        end else if (advance_i) begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/tx_stream_packer.sv
// N-channel packetiser: captures wide channel words, arbitrates round robin and
// serialises header/data/trailer words into the tx FIFO.
module tx_stream_packer
    import tx_pkg::*;
#(
    parameter int unsigned N_CH   = 3,
    parameter int unsigned IN_W   = 128,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned HDR_EN = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        ch_enable,
    input  logic [N_CH*IN_W-1:0]   in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_busy,
    input  logic                   frame_complete,
    output logic [OUT_W-1:0]       fifo_din,
    output logic                   fifo_wr_en,
    input  logic                   fifo_block_full,
    output logic [DROP_W-1:0]      drop_count,
    output logic                   idle
);

    localparam int unsigned BEATS      = IN_W / OUT_W;
    localparam int unsigned BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned DROP_SUM_W = DROP_W + 1;

    state_e                 state_q, state_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [SEQ_W-1:0]       seq_q, seq_d;
    logic [PKT_CNT_W-1:0]   frame_pkt_q, frame_pkt_d;
    logic                   frame_pend_q, frame_pend_d;
    logic [N_CH-1:0]        frame_mask_q, frame_mask_d;
    logic [N_CH-1:0]        busy_q, busy_d;
    logic [IN_W-1:0]        hold_q [N_CH];
    logic [IN_W-1:0]        hold_d [N_CH];
    logic [DROP_W-1:0]      drop_q, drop_d;
    logic [OUT_W-1:0]       din_q, din_d;
    logic                   wr_q, wr_d;
    logic                   idle_q, idle_d;

    logic [N_CH-1:0]        req_c;
    logic [N_CH-1:0]        grant_c;
    logic [CH_W-1:0]        grant_idx_c;
    logic                   advance_c;
    logic [4:0]             drop_inc_c;
    logic [DROP_SUM_W-1:0]  drop_sum_c;
    logic [IN_W-1:0]        shifted_c;
    hdr_word_t              hdr_c;
    trl_word_t              trl_c;

    // While a frame is closing only its snapshot channels may be granted.
    assign req_c = busy_q & (frame_pend_q ? frame_mask_q : {N_CH{1'b1}});

    rr_arbiter #(.N(N_CH)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_c),
        .advance_i (advance_c),
        .grant_c_o (grant_c)
    );

    always_comb begin
        grant_idx_c = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (grant_c[i]) grant_idx_c = CH_W'(i);
        end
    end

    assign shifted_c = hold_q[ch_q] << (32'(beat_q) * OUT_W);

    always_comb begin
        hdr_c         = '0;
        hdr_c.sync    = HDR_SYNC;
        hdr_c.ch      = HDR_CH_W'(ch_q);
        hdr_c.seq     = seq_q;
        trl_c         = '0;
        trl_c.sync    = TRL_SYNC;
        trl_c.pkt_cnt = frame_pkt_q;
    end

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        beat_d       = beat_q;
        seq_d        = seq_q;
        frame_pkt_d  = frame_pkt_q;
        frame_pend_d = frame_pend_q;
        frame_mask_d = frame_mask_q;
        busy_d       = busy_q;
        hold_d       = hold_q;
        din_d        = din_q;
        wr_d         = 1'b0;
        advance_c    = 1'b0;
        drop_inc_c   = '0;

        for (int i = 0; i < int'(N_CH); i++) begin
            if (in_valid[i] && ch_enable[i]) begin
                if (busy_q[i]) begin
                    drop_inc_c = drop_inc_c + 5'd1;
                end else begin
                    busy_d[i] = 1'b1;
                    hold_d[i] = in_data[i*IN_W +: IN_W];
                end
            end
        end
        drop_sum_c = {1'b0, drop_q} + DROP_SUM_W'(drop_inc_c);
        drop_d     = drop_sum_c[DROP_W] ? {DROP_W{1'b1}} : drop_sum_c[DROP_W-1:0];

        unique case (state_q)
            ST_IDLE: begin
                if (req_c != '0) begin
                    advance_c = 1'b1;
                    ch_d      = grant_idx_c;
                    beat_d    = '0;
                    state_d   = (HDR_EN != 0) ? ST_HDR : ST_DATA;
                end else if (frame_pend_q && frame_mask_q == '0) begin
                    state_d = ST_TRL;
                end
            end
            ST_HDR: begin
                if (!fifo_block_full) begin
                    wr_d    = 1'b1;
                    din_d   = OUT_W'(hdr_c);
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!fifo_block_full) begin
                    wr_d  = 1'b1;
                    din_d = shifted_c[IN_W-1 -: OUT_W];
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        busy_d[ch_q]       = 1'b0;
                        frame_mask_d[ch_q] = 1'b0;
                        seq_d              = seq_q + 1'b1;
                        frame_pkt_d        = frame_pkt_q + 1'b1;
                        state_d            = ST_IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_TRL: begin
                if (!fifo_block_full) begin
                    wr_d         = 1'b1;
                    din_d        = OUT_W'(trl_c);
                    frame_pkt_d  = '0;
                    frame_pend_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Snapshot uses next-cycle occupancy: same-cycle captures in, just-finished packet out.
        if (frame_complete && !frame_pend_q) begin
            frame_pend_d = 1'b1;
            frame_mask_d = busy_d;
        end

        idle_d = (state_d == ST_IDLE) && (busy_d == '0) && !frame_pend_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ch_q         <= '0;
            beat_q       <= '0;
            seq_q        <= '0;
            frame_pkt_q  <= '0;
            frame_pend_q <= 1'b0;
            frame_mask_q <= '0;
            busy_q       <= '0;
            hold_q       <= '{default: '0};
            drop_q       <= '0;
            din_q        <= '0;
            wr_q         <= 1'b0;
            idle_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            beat_q       <= beat_d;
            seq_q        <= seq_d;
            frame_pkt_q  <= frame_pkt_d;
            frame_pend_q <= frame_pend_d;
            frame_mask_q <= frame_mask_d;
            busy_q       <= busy_d;
            hold_q       <= hold_d;
            drop_q       <= drop_d;
            din_q        <= din_d;
            wr_q         <= wr_d;
            idle_q       <= idle_d;
        end
    end

    assign in_busy    = busy_q;
    assign fifo_din   = din_q;
    assign fifo_wr_en = wr_q;
    assign drop_count = drop_q;
    assign idle       = idle_q;

endmodule

// File: tb/tb_tx_stream_packer.sv
// Directed bench for tx_stream_packer: packet framing, round robin, stall, drops, frames, reset.
module tb_tx_stream_packer;

    localparam int unsigned N_CH  = 3;
    localparam int unsigned IN_W  = 128;
    localparam int unsigned OUT_W = 32;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N_CH-1:0]      ch_enable;
    logic [N_CH*IN_W-1:0] in_data;
    logic [N_CH-1:0]      in_valid;
    logic [N_CH-1:0]      in_busy;
    logic                 frame_complete;
    logic [OUT_W-1:0]     fifo_din;
    logic                 fifo_wr_en;
    logic                 fifo_block_full;
    logic [15:0]          drop_count;
    logic                 idle;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] mon_q [$];

    tx_stream_packer #(
        .N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W), .HDR_EN(1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ch_enable       (ch_enable),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_busy         (in_busy),
        .frame_complete  (frame_complete),
        .fifo_din        (fifo_din),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_block_full (fifo_block_full),
        .drop_count      (drop_count),
        .idle            (idle)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && fifo_wr_en === 1'b1) mon_q.push_back(fifo_din);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] w(input int c, input int k);
        return 32'hDA000000 | (32'(c) << 8) | 32'(k);
    endfunction

    function automatic logic [IN_W-1:0] pat(input int c);
        return {w(c, 0), w(c, 1), w(c, 2), w(c, 3)};
    endfunction

    task automatic do_reset();
        rst_n           = 1'b0;
        in_valid        = '0;
        frame_complete  = 1'b0;
        fifo_block_full = 1'b0;
        ch_enable       = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_q.delete();
    endtask

    // Drive valid for exactly one capture edge; returns 1 time unit after that edge.
    task automatic pulse(input logic [N_CH-1:0] mask, input logic [N_CH*IN_W-1:0] data);
        in_valid = mask;
        in_data  = data;
        tick();
        in_valid = '0;
    endtask

    // Wait (bounded) for n words, let the block settle, then require exactly n.
    task automatic wait_words(input string tag, input int n);
        int cyc = 0;
        while (mon_q.size() < n && cyc < 500) begin
            tick();
            cyc++;
        end
        repeat (8) tick();
        check(tag, 32'(mon_q.size()), 32'(n));
    endtask

    task automatic expect_word(input string tag, input logic [31:0] exp);
        logic [31:0] got;
        got = 'x;
        if (mon_q.size() > 0) got = mon_q.pop_front();
        check(tag, got, exp);
    endtask

    task automatic expect_packet(input string tag, input int c, input int seq);
        expect_word({tag, "_hdr"}, {8'hA5, 4'(c), 4'h0, 16'(seq)});
        for (int k = 0; k < 4; k++) expect_word({tag, "_beat"}, w(c, k));
    endtask

    initial begin
        in_data = '0;
        do_reset();

        // Reset state
        check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("rst_din",   fifo_din,        32'd0);
        check("rst_busy",  32'(in_busy),    32'd0);
        check("rst_drop",  32'(drop_count), 32'd0);
        check("rst_idle",  32'(idle),       32'd1);

        // Test 1: single packet, latency and MSB-first beats
        pulse(3'b001, {256'd0, 128'h00112233_44556677_8899AABB_CCDDEEFF});
        check("t1_busy", 32'(in_busy), 32'b001);
        tick();
        check("t1_wr_n1", 32'(fifo_wr_en), 32'd0);
        tick();
        check("t1_wr_n2",  32'(fifo_wr_en), 32'd1);
        check("t1_din_n2", fifo_din,        32'hA5000000);
        wait_words("t1_cnt", 5);
        expect_word("t1_w0", 32'hA5000000);
        expect_word("t1_w1", 32'h00112233);
        expect_word("t1_w2", 32'h44556677);
        expect_word("t1_w3", 32'h8899AABB);
        expect_word("t1_w4", 32'hCCDDEEFF);
        check("t1_idle", 32'(idle), 32'd1);

        // Test 2: round robin across simultaneous requests
        do_reset();
        pulse(3'b111, {pat(2), pat(1), pat(0)});
        wait_words("t2a_cnt", 15);
        expect_packet("t2a_p0", 0, 0);
        expect_packet("t2a_p1", 1, 1);
        expect_packet("t2a_p2", 2, 2);
        pulse(3'b111, {pat(2), pat(1), pat(0)});
        wait_words("t2b_cnt", 15);
        expect_packet("t2b_p0", 0, 3);
        expect_packet("t2b_p1", 1, 4);
        expect_packet("t2b_p2", 2, 5);
        pulse(3'b001, {pat(2), pat(1), pat(0)});
        wait_words("t2c_cnt", 5);
        expect_packet("t2c_p0", 0, 6);
        pulse(3'b101, {pat(2), pat(1), pat(0)});
        wait_words("t2d_cnt", 10);
        expect_packet("t2d_p2", 2, 7);
        expect_packet("t2d_p0", 0, 8);

        // Test 3: three-cycle stall mid-DATA
        do_reset();
        pulse(3'b010, {pat(2), pat(1), pat(0)});
        tick();
        tick();
        tick();
        check("t3_beat0_wr", 32'(fifo_wr_en), 32'd1);
        fifo_block_full = 1'b1;
        tick();
        check("t3_stall1_wr",  32'(fifo_wr_en), 32'd0);
        check("t3_stall1_din", fifo_din,        w(1, 0));
        tick();
        check("t3_stall2_wr", 32'(fifo_wr_en), 32'd0);
        tick();
        check("t3_stall3_wr", 32'(fifo_wr_en), 32'd0);
        fifo_block_full = 1'b0;
        wait_words("t3_cnt", 5);
        expect_packet("t3_p1", 1, 0);

        // Test 4: drop on busy channel, disabled channel ignored
        do_reset();
        pulse(3'b010, {pat(2), pat(1), pat(0)});
        pulse(3'b010, {pat(2), pat(2), pat(0)});
        check("t4_drop1", 32'(drop_count), 32'd1);
        ch_enable = 3'b011;
        pulse(3'b100, {pat(2), pat(1), pat(0)});
        check("t4_drop_dis", 32'(drop_count), 32'd1);
        check("t4_busy_dis", 32'(in_busy[2]), 32'd0);
        ch_enable = 3'b111;
        wait_words("t4_cnt", 5);
        expect_packet("t4_p1", 1, 0);

        // Test 5: frames
        do_reset();
        frame_complete = 1'b1;
        tick();
        frame_complete = 1'b0;
        wait_words("t5a_cnt", 1);
        expect_word("t5a_trl", 32'h5A000000);
        pulse(3'b011, {pat(2), pat(1), pat(0)});
        frame_complete = 1'b1;
        tick();
        frame_complete = 1'b0;
        pulse(3'b100, {pat(2), pat(1), pat(0)});
        wait_words("t5b_cnt", 16);
        expect_packet("t5b_p0", 0, 0);
        expect_packet("t5b_p1", 1, 1);
        expect_word("t5b_trl", 32'h5A000002);
        expect_packet("t5b_p2", 2, 2);

        // Test 6: reset mid-DATA
        do_reset();
        pulse(3'b001, {pat(2), pat(1), pat(0)});
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_wr_en", 32'(fifo_wr_en), 32'd0);
        check("t6_busy",  32'(in_busy),    32'd0);
        check("t6_idle",  32'(idle),       32'd1);
        tick();
        rst_n = 1'b1;
        mon_q.delete();
        pulse(3'b100, {pat(2), pat(1), pat(0)});
        wait_words("t6_cnt", 5);
        expect_packet("t6_p2", 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
